// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU command driver: opcodes, FSM states,
// flag bit positions and a small opcode classification helper.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_LT  = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    localparam int FLG_OV = 3;
    localparam int FLG_CY = 2;
    localparam int FLG_LT = 1;
    localparam int FLG_EQ = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Compare opcodes leave the accumulator alone and only report compare/equal.
    function automatic logic is_cmp(input logic [2:0] opcode);
        return (opcode == ALU_LT) || (opcode == ALU_EQ);
    endfunction

endpackage

// File: rtl/alu_wait_cnt.sv
// Loadable down-counter with a zero flag; stretches EXEC by ALU_LAT cycles
// for ALUs that need more than one cycle to settle.
module alu_wait_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    // Load has priority over decrement; the counter parks at zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/alu_cmd_driver.sv
// Accumulator-machine front end for an external combinational ALU.
// Commands arrive on a valid/ready handshake, operands are held stable in
// EXEC while the ALU settles, and the result/flags return on a second
// valid/ready handshake.
// Optional build macro: ALU_STICKY_FLAGS_EN makes overflow/carry accumulate
// across ALU operations until reset or a load command.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int ALU_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    input  logic             alu_compare,
    input  logic             alu_equal,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_acc,
    output logic [3:0]       rsp_flags
);

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] op2_reg;
    logic [2:0]       opcode_reg;
    logic [3:0]       flags_reg;
    logic [3:0]       flags_next;
    logic             accept;
    logic             capture;
    logic             cnt_zero;

    alu_wait_cnt #(
        .CNT_W (4)
    ) u_wait_cnt (
        .clk      (clk),
        .srst     (rst),
        .load     (accept && !cmd_load),
        .load_val (LAT_INIT),
        .dec      (state_reg == EXEC),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus handshake outputs and datapath strobes.
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = cmd_load ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt_zero) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Flag word captured at the end of EXEC; compare ops report only
    // compare/equal, all other ops only overflow/carry.
    always_comb begin
        flags_next = '0;
        if (is_cmp(opcode_reg)) begin
            flags_next[FLG_LT] = alu_compare;
            flags_next[FLG_EQ] = alu_equal;
        end else begin
            flags_next[FLG_OV] = alu_overflow;
            flags_next[FLG_CY] = alu_carry;
        end
`ifdef ALU_STICKY_FLAGS_EN
        flags_next[FLG_OV] = flags_next[FLG_OV] | flags_reg[FLG_OV];
        flags_next[FLG_CY] = flags_next[FLG_CY] | flags_reg[FLG_CY];
`endif
    end

    // Accumulator, operand/opcode registers and flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg    <= '0;
            op2_reg    <= '0;
            opcode_reg <= '0;
            flags_reg  <= '0;
        end else if (accept) begin
            if (cmd_load) begin
                acc_reg   <= cmd_operand;
                flags_reg <= '0;
            end else begin
                op2_reg    <= cmd_operand;
                opcode_reg <= cmd_opcode;
            end
        end else if (capture) begin
            if (!is_cmp(opcode_reg)) begin
                acc_reg <= alu_out;
            end
            flags_reg <= flags_next;
        end
    end

    assign alu_op1    = acc_reg;
    assign alu_op2    = op2_reg;
    assign alu_opcode = opcode_reg;
    assign rsp_acc    = acc_reg;
    assign rsp_flags  = flags_reg;

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator side of the 4-bit ALU interface: accepts commands over a valid/ready handshake, holds an accumulator, and drives operands and opcode to an external combinational ALU.
- Captures the ALU result and flags, writes them back, and returns a response over a second valid/ready handshake.
- Sits between a test or program sequencer and the ALU, forming a small accumulator machine.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- ALU_LAT, 0, extra wait cycles in EXEC before capturing the ALU outputs (0 = combinational ALU). Range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  driver can accept a command.
- cmd_load  input  1  1 = load operand into acc, no ALU issue.
- cmd_opcode  input  3  ALU opcode: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 lt, 111 eq.
- cmd_operand  input  WIDTH  second operand, or load value.
- alu_op1  output  WIDTH  to ALU op1; equals acc.
- alu_op2  output  WIDTH  to ALU op2; registered operand.
- alu_opcode  output  3  to ALU opcode; registered.
- alu_out  input  WIDTH  ALU result.
- alu_overflow, alu_carry, alu_compare, alu_equal  input  1 each  ALU flags.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_acc  output  WIDTH  accumulator after the command.
- rsp_flags  output  4  {overflow, carry, compare, equal} flag register.

Behaviour:
- Reset: state IDLE; acc=0; flags=0; op2 and opcode registers 0; cmd_ready=1; rsp_valid=0. Reset applies from any state and aborts any in-flight command with no response.
- States: IDLE, EXEC, RESP. cmd_ready=1 only in IDLE. rsp_valid=1 only in RESP.
- IDLE with cmd_valid=1:
  - cmd_load=1: acc<=cmd_operand, flags<=0, go to RESP.
  - cmd_load=0: op2<=cmd_operand, opcode<=cmd_opcode, wait counter<=ALU_LAT, go to EXEC.
- EXEC:
  - alu_op1, alu_op2 and alu_opcode are driven from registers and are stable for the whole state.
  - Counter decrements each cycle.
  - On the edge where counter==0, capture and go to RESP:
    - opcode 000..101: acc<=alu_out; flags<={alu_overflow, alu_carry, 0, 0}.
    - opcode 110/111: acc unchanged; flags<={0, 0, alu_compare, alu_equal}.
- Latency: command accepted at edge N → rsp_valid high from cycle N+2+ALU_LAT (ALU op) or N+1 (load).
- RESP:
  - rsp_acc and rsp_flags are held stable while rsp_valid=1 and rsp_ready=0.
  - rsp_valid&&rsp_ready → IDLE; cmd_ready rises the following cycle. No command is accepted in the same cycle as a response.
- Arithmetic: WIDTH-bit wrap-around is done by the ALU; the driver never modifies alu_out.
- Outside EXEC, alu_op1 still tracks acc and alu_op2/alu_opcode hold their last values; results are ignored.
- Ignored inputs: cmd_* ignored when cmd_ready=0. rsp_ready ignored when rsp_valid=0.

Optional Feature:
- Macro ALU_STICKY_FLAGS_EN.
- Defined: the overflow and carry bits OR-accumulate across ALU ops; they clear only on reset or a load command. compare and equal are unchanged (non-sticky).
- Undefined: the flags register is fully rewritten on each capture as described in Behaviour.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (ALU_ADD..ALU_EQ);
  - state enum (IDLE/EXEC/RESP);
  - flag bit index constants (FLG_OV=3, FLG_CY=2, FLG_LT=1, FLG_EQ=0).
- One natural sub-module: alu_wait_cnt, a loadable down-counter with a zero flag, used for the ALU_LAT wait.

Test Plan:
- Reset then load 4'h7 → rsp_acc=7, rsp_flags=0000, rsp_valid one cycle after acceptance.
- acc=7, add 1 → rsp_acc=8, rsp_flags=1000 (overflow); acc=15, add 1 → rsp_acc=0, flags=0100 (carry).
- acc=3, sub 5 → rsp_acc=14; then lt 5 → acc stays 14, flags=0000; eq 14 → flags=0001.
- ALU_LAT=3: add accepted at edge N → rsp_valid first high at N+5; alu_op1/alu_op2/alu_opcode constant for cycles N+1..N+4.
- Hold rsp_ready=0 for 4 cycles → rsp_acc/flags stable, cmd_ready=0 and cmd_valid ignored; then rsp_ready=1 → cmd_ready=1 the following cycle.
- Assert rst during EXEC → next cycle IDLE, acc=0, rsp_valid=0, no response emitted. With ALU_STICKY_FLAGS_EN: add overflow then xor → overflow bit stays 1.
